// File: rtl/riscv_alu_exec_pipe_if.sv
// Handshake bundle between decode, the ALU execute pipe and write-back.
// slave = execute stage view, master = the surrounding core / bench.
interface riscv_alu_exec_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_result;
  logic [3:0]      out_flags;
  logic            out_illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_flags, out_illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_flags, out_illegal
  );
endinterface

// File: rtl/riscv_alu_exec_pipe.sv
// RISC-V integer execute stage: R/I ALU, LUI, AUIPC with {Z,N,C,V} flags through STAGES elastic slots.
// Optional ALU_MUL_EN macro adds R-type MUL (low XLEN bits); without it funct7=0000001 is illegal.
module riscv_alu_exec_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  riscv_alu_exec_pipe_if.slave io
);

  localparam int SH = $clog2(XLEN);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // {alt, funct3}; alt selects SUB/SRA, MUL takes the otherwise unused 1001
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic            illegal;
    logic [3:0]      flags;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } slot_t;

  localparam slot_t SLOT_RST = '{illegal: 1'b0, flags: 4'b1000, rd: 5'd0, result: '0};

  // ---------------- decode ----------------
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_u;
  logic [XLEN-1:0] op_a, op_b;
  logic [SH-1:0]   shamt;
  logic [3:0]      alu_op;
  logic            legal;

  always_comb begin
    opcode       = io.instr[6:0];
    f3           = io.instr[14:12];
    f7           = io.instr[31:25];
    imm_i        = {XLEN{io.instr[31]}};
    imm_i[11:0]  = io.instr[31:20];
    imm_u        = {XLEN{io.instr[31]}};
    imm_u[31:0]  = {io.instr[31:12], 12'b0};
    op_a         = io.rs1_val;
    op_b         = io.rs2_val;
    shamt        = io.rs2_val[SH-1:0];
    alu_op       = ALU_ADD;
    legal        = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7 == 7'b0000000) begin
          legal  = 1'b1;
          alu_op = {1'b0, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal  = 1'b1;
          alu_op = {1'b1, f3};
        end
`ifdef ALU_MUL_EN
        else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_MUL;
        end
`endif
      end
      OP_I: begin
        op_b  = imm_i;
        shamt = io.instr[20 +: SH];
        case (f3)
          3'b001: begin
            legal  = (f7[6:1] == 6'b000000);
            alu_op = ALU_SLL;
          end
          3'b101: begin
            legal  = (f7[6:1] == 6'b000000) || (f7[6:1] == 6'b010000);
            alu_op = f7[5] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            legal  = 1'b1;
            alu_op = {1'b0, f3};
          end
        endcase
      end
      // LUI is 0 + imm on the adder: carry and overflow are necessarily 0
      OP_LUI: begin
        legal = 1'b1;
        op_a  = '0;
        op_b  = imm_u;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        op_a  = io.pc;
        op_b  = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // ---------------- execute ----------------
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] res;
  logic            c_fl, v_fl;
  slot_t           slot_d;

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mul_res;
  assign mul_res = op_a * op_b;
`endif

  always_comb begin
    sum  = {1'b0, op_a} + {1'b0, op_b};
    diff = op_a - op_b;
    res  = '0;
    c_fl = 1'b0;
    v_fl = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        res  = sum[XLEN-1:0];
        c_fl = sum[XLEN];
        v_fl = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SUB: begin
        res  = diff;
        c_fl = (op_a < op_b);
        v_fl = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SLL:  res = op_a << shamt;
      ALU_SLT:  res[0] = ($signed(op_a) < $signed(op_b));
      ALU_SLTU: res[0] = (op_a < op_b);
      ALU_XOR:  res = op_a ^ op_b;
      ALU_SRL:  res = op_a >> shamt;
      ALU_SRA:  res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   res = op_a | op_b;
      ALU_AND:  res = op_a & op_b;
`ifdef ALU_MUL_EN
      ALU_MUL:  res = mul_res;
`endif
      default:  res = '0;
    endcase

    slot_d.rd      = io.instr[11:7];
    slot_d.illegal = !legal;
    if (legal) begin
      slot_d.result = res;
      slot_d.flags  = {(res == '0), res[XLEN-1], c_fl, v_fl};
    end else begin
      slot_d.result = '0;
      slot_d.flags  = 4'b1000;
    end
  end

  // ---------------- elastic slots ----------------
  logic [STAGES-1:0] vld_q, vld_d, adv;
  logic [STAGES:0]   rdy;
  logic              accept;
  slot_t             slot_q [STAGES];

  // Ready ripples back from write-back so a full pipe still moves every cycle.
  always_comb begin
    rdy[STAGES] = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] && rdy[k+1];
      rdy[k] = !vld_q[k] || adv[k];
    end
  end

  assign io.in_ready = rdy[0];
  assign accept      = io.in_valid && rdy[0] && !flush;

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) vld_d[k] = 1'b0;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k-1]) vld_d[k] = 1'b1;
    end
    if (accept) vld_d[0] = 1'b1;
    if (flush)  vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) slot_q[k] <= SLOT_RST;
    end else begin
      if (accept) slot_q[0] <= slot_d;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1]) slot_q[k] <= slot_q[k-1];
      end
    end
  end

  assign io.out_valid   = vld_q[STAGES-1];
  assign io.out_rd      = slot_q[STAGES-1].rd;
  assign io.out_result  = slot_q[STAGES-1].result;
  assign io.out_flags   = slot_q[STAGES-1].flags;
  assign io.out_illegal = slot_q[STAGES-1].illegal;

endmodule

// File: tb/tb_riscv_alu_exec_pipe.sv
// Directed bench for riscv_alu_exec_pipe (XLEN=32, STAGES=2): decode/flags vectors, stall stream, flush, reset.
module tb_riscv_alu_exec_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic rst, flush;
  int   n_chk = 0;
  int   n_err = 0;

  riscv_alu_exec_pipe_if #(.XLEN(XLEN)) io ();

  riscv_alu_exec_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Entered and left at posedge+1; the transfer happens on the edge in between.
  task automatic push(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] a, input logic [31:0] b);
    io.instr    = ins;
    io.pc       = pcv;
    io.rs1_val  = a;
    io.rs2_val  = b;
    io.in_valid = 1'b1;
    #1;
    for (int k = 0; k < 50 && !io.in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!io.in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [31:0] ins, input logic [31:0] pcv,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic [3:0] exp_fl, input logic exp_ill);
    io.out_ready = 1'b1;
    push(ins, pcv, a, b);
    chk({tag, "_lat"}, io.out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, io.out_valid, 1);
    chk({tag, "_res"}, io.out_result, exp_res);
    chk({tag, "_flg"}, io.out_flags, exp_fl);
    chk({tag, "_rd"},  io.out_rd, ins[11:7]);
    chk({tag, "_ill"}, io.out_illegal, exp_ill);
  endtask

  logic [31:0] s_exp [8];
  logic [4:0]  s_rd  [8];
  logic [3:0]  pat;
  int          n_sent, n_recv, seen;

  initial begin
    rst = 1'b1; flush = 1'b0;
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.instr = '0; io.pc = '0; io.rs1_val = '0; io.rs2_val = '0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", io.out_valid, 0);
    chk("rst_flg", io.out_flags, 4'b1000);
    chk("rst_res", io.out_result, 0);
    chk("rst_rd",  io.out_rd, 0);
    chk("rst_ill", io.out_illegal, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", io.in_ready, 1);

    // decode and flag vectors, flags are {Z,N,C,V}
    vec("add_ovf", enc_r(7'h00, 3'b000, 5'd5), 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101, 0);
    vec("sub_brw", enc_r(7'h20, 3'b000, 5'd6), 0, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0110, 0);
    vec("sub_ok",  enc_r(7'h20, 3'b000, 5'd6), 0, 32'd5, 32'd3, 32'd2, 4'b0000, 0);
    vec("sub_ovf", enc_r(7'h20, 3'b000, 5'd6), 0, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0001, 0);
    vec("srai",    enc_i(12'h404, 3'b101, 5'd7, OP_I), 0, 32'h80000000, 0, 32'hF8000000, 4'b0100, 0);
    vec("slt",     enc_r(7'h00, 3'b010, 5'd8), 0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0000, 0);
    vec("sltu",    enc_r(7'h00, 3'b011, 5'd9), 0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1000, 0);
    vec("xori",    enc_i(12'hFFF, 3'b100, 5'd10, OP_I), 0, 32'h00000F0F, 0, 32'hFFFFF0F0, 4'b0100, 0);
    vec("lui",     enc_u(20'h12345, 5'd11, OP_LUI), 0, 0, 0, 32'h12345000, 4'b0000, 0);
    vec("auipc",   enc_u(20'h80000, 5'd12, OP_AUIPC), 32'h80000000, 0, 0, 32'h0, 4'b1011, 0);
    vec("addi_c",  enc_i(12'h001, 3'b000, 5'd13, OP_I), 0, 32'hFFFFFFFF, 0, 32'h0, 4'b1010, 0);
    vec("sll_msk", enc_r(7'h00, 3'b001, 5'd14), 0, 32'd1, 32'h3F, 32'h80000000, 4'b0100, 0);
    vec("srl",     enc_r(7'h00, 3'b101, 5'd15), 0, 32'h80000000, 32'h1F, 32'd1, 4'b0000, 0);
    vec("and",     enc_r(7'h00, 3'b111, 5'd17), 0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 0);
    vec("add_rd0", enc_r(7'h00, 3'b000, 5'd0), 0, 32'd2, 32'd3, 32'd5, 4'b0000, 0);
    vec("load",    enc_i(12'h004, 3'b010, 5'd16, 7'b0000011), 0, 32'd9, 0, 32'd0, 4'b1000, 1);
    vec("bad_sri", enc_i(12'h604, 3'b101, 5'd16, OP_I), 0, 32'd9, 0, 32'd0, 4'b1000, 1);
    vec("bad_and", enc_r(7'h20, 3'b111, 5'd16), 0, 32'd9, 32'd9, 32'd0, 4'b1000, 1);
`ifdef ALU_MUL_EN
    vec("mul",     enc_r(7'h01, 3'b000, 5'd18), 0, 32'd6, 32'd7, 32'd42, 4'b0000, 0);
`else
    vec("mul",     enc_r(7'h01, 3'b000, 5'd18), 0, 32'd6, 32'd7, 32'd0, 4'b1000, 1);
`endif
    vec("mulh",    enc_r(7'h01, 3'b001, 5'd18), 0, 32'd6, 32'd7, 32'd0, 4'b1000, 1);

    // stream of 8 ADDIs against out_ready 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      s_exp[i] = 32'(i * 16 + i + 1);
      s_rd[i]  = 5'(i + 1);
    end
    pat = 4'b1001;
    n_sent = 0; n_recv = 0;
    for (int cyc = 0; cyc < 200 && n_recv < 8; cyc++) begin
      @(posedge clk); #1;
      io.out_ready = pat[cyc % 4];
      if (n_sent < 8) begin
        io.instr    = enc_i(12'(n_sent + 1), 3'b000, s_rd[n_sent], OP_I);
        io.rs1_val  = 32'(n_sent * 16);
        io.in_valid = 1'b1;
      end else begin
        io.in_valid = 1'b0;
      end
      #1;
      if (io.out_valid) begin
        chk("stream_res", io.out_result, s_exp[n_recv]);
        chk("stream_rd",  io.out_rd, s_rd[n_recv]);
        if (io.out_ready) n_recv++;
      end
      if (io.in_valid && io.in_ready) n_sent++;
    end
    chk("stream_cnt", n_recv, 8);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (io.out_valid) seen++;
    end
    chk("stream_dup", seen, 0);

    // flush with a full pipe and a simultaneous input
    io.out_ready = 1'b0;
    push(enc_i(12'h011, 3'b000, 5'd20, OP_I), 0, 0, 0);
    push(enc_i(12'h022, 3'b000, 5'd21, OP_I), 0, 0, 0);
    #1;
    chk("full_vld", io.out_valid, 1);
    chk("full_rdy", io.in_ready, 0);
    chk("full_res", io.out_result, 32'h11);
    flush = 1'b1;
    io.instr = enc_i(12'h055, 3'b000, 5'd31, OP_I);
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    chk("flush_vld", io.out_valid, 0);
    io.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (io.out_valid) seen++;
    end
    chk("flush_drop", seen, 0);
    chk("flush_rdy", io.in_ready, 1);

    // reset together with flush while stalled
    io.out_ready = 1'b0;
    push(enc_r(7'h00, 3'b000, 5'd22), 0, 32'd1, 32'd1);
    push(enc_r(7'h00, 3'b000, 5'd23), 0, 32'd2, 32'd2);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    chk("rstf_vld", io.out_valid, 0);
    chk("rstf_flg", io.out_flags, 4'b1000);
    chk("rstf_res", io.out_result, 0);
    chk("rstf_rd",  io.out_rd, 0);
    io.out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (io.out_valid) seen++;
    end
    chk("rstf_drop", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
